// File: rtl/snake_engine.sv
// ---------------------------------------------------------------------------
// snake_engine
//   Parametrised snake game core. The body lives in a circular buffer of
//   MAX_LEN = 2^LEN_BITS segments addressed relative to head_ptr; segment 0
//   is the head. Each accepted step computes the next head cell, checks the
//   wall and the body (one segment per clock), then commits the move.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   step, dir           one-cycle advance request, direction (00 +x, 01 -x,
//                       10 +y, 11 -y)
//   food_x, food_y      current food cell
//   restart             one-cycle request to re-run init, clears game_over
//   rd_idx              readback segment index (0 = head)
//   rd_x, rd_y, rd_valid registered readback, zero when rd_idx >= length
//   busy                engine not idle (includes the done cycle)
//   done, ate           end-of-step pulse, food-entered pulse
//   game_over           sticky collision flag
//   length              current segment count
//   head_x, head_y      current head position
// ---------------------------------------------------------------------------
module snake_engine #(
  parameter int X_BITS   = 4,
  parameter int Y_BITS   = 4,
  parameter int LEN_BITS = 6,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 4,
  parameter int INIT_Y   = 4,
  parameter int WRAP     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step,
  input  logic [1:0]          dir,
  input  logic [X_BITS-1:0]   food_x,
  input  logic [Y_BITS-1:0]   food_y,
  input  logic                restart,
  input  logic [LEN_BITS-1:0] rd_idx,
  output logic [X_BITS-1:0]   rd_x,
  output logic [Y_BITS-1:0]   rd_y,
  output logic                rd_valid,
  output logic                busy,
  output logic                done,
  output logic                ate,
  output logic                game_over,
  output logic [LEN_BITS:0]   length,
  output logic [X_BITS-1:0]   head_x,
  output logic [Y_BITS-1:0]   head_y
);

  localparam int MAX_LEN = 1 << LEN_BITS;
  localparam logic [X_BITS-1:0] X_MAX = '1;
  localparam logic [Y_BITS-1:0] Y_MAX = '1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CALC,
    S_SCAN,
    S_COMMIT,
    S_OVER
  } state_t;

  state_t state_reg, state_next;

  // Body storage, written only in INIT and COMMIT.
  logic [X_BITS-1:0] body_x [MAX_LEN];
  logic [Y_BITS-1:0] body_y [MAX_LEN];

  logic [LEN_BITS-1:0] head_ptr_reg;
  logic [LEN_BITS-1:0] init_cnt_reg;
  logic [LEN_BITS:0]   length_reg;
  logic [LEN_BITS:0]   scan_cnt_reg;
  logic [LEN_BITS:0]   scan_last_reg;
  logic [X_BITS-1:0]   head_x_reg, nx_reg;
  logic [Y_BITS-1:0]   head_y_reg, ny_reg;
  logic [1:0]          cur_dir_reg;
  logic                eat_reg;
  logic                done_reg, ate_reg, game_over_reg;
  logic                rd_valid_reg;
  logic [X_BITS-1:0]   rd_x_reg;
  logic [Y_BITS-1:0]   rd_y_reg;

  // ---------------------------------------------------------------- CALC
  logic [1:0]        rev_dir, new_dir;
  logic [X_BITS-1:0] nx_calc;
  logic [Y_BITS-1:0] ny_calc;
  logic              wall_calc, eat_calc;
  logic [LEN_BITS:0] k_last_calc;

  always_comb begin
    rev_dir   = {cur_dir_reg[1], ~cur_dir_reg[0]};
    new_dir   = (dir == rev_dir) ? cur_dir_reg : dir;
    nx_calc   = head_x_reg;
    ny_calc   = head_y_reg;
    wall_calc = 1'b0;
    case (new_dir)
      2'b00: begin nx_calc = head_x_reg + X_BITS'(1); wall_calc = (head_x_reg == X_MAX); end
      2'b01: begin nx_calc = head_x_reg - X_BITS'(1); wall_calc = (head_x_reg == '0);    end
      2'b10: begin ny_calc = head_y_reg + Y_BITS'(1); wall_calc = (head_y_reg == Y_MAX); end
      default: begin ny_calc = head_y_reg - Y_BITS'(1); wall_calc = (head_y_reg == '0);  end
    endcase
    eat_calc = (nx_calc == food_x) && (ny_calc == food_y);
    // Index of the last segment to scan. Without eating, the tail cell is
    // vacated in the same move and so is excluded.
    k_last_calc = eat_calc ? (length_reg - (LEN_BITS+1)'(1))
                           : (length_reg - (LEN_BITS+1)'(2));
  end

  // ---------------------------------------------------------------- SCAN
  logic [LEN_BITS-1:0] scan_addr;
  logic                seg_hit, scan_end, init_last, step_ok;

  assign scan_addr = head_ptr_reg + scan_cnt_reg[LEN_BITS-1:0];
  assign seg_hit   = (body_x[scan_addr] == nx_reg) && (body_y[scan_addr] == ny_reg);
  assign scan_end  = (scan_cnt_reg == scan_last_reg);
  assign init_last = (init_cnt_reg == LEN_BITS'(INIT_LEN - 1));
  // The done cycle still counts as busy, so a step there is dropped.
  assign step_ok   = step && !done_reg && !game_over_reg;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_INIT;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    case (state_reg)
      S_INIT: if (init_last) state_next = S_IDLE;
      S_IDLE: begin
        busy = done_reg;
        if (restart)      state_next = S_INIT;
        else if (step_ok) state_next = S_CALC;
      end
      S_CALC: begin
        if (WRAP == 0 && wall_calc) state_next = S_OVER;
        else                        state_next = S_SCAN;
      end
      S_SCAN: begin
        if (seg_hit)       state_next = S_OVER;
        else if (scan_end) state_next = S_COMMIT;
      end
      S_COMMIT: state_next = S_IDLE;
      S_OVER:   if (restart) state_next = S_INIT;
      default:  state_next = S_INIT;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr_reg  <= '0;
      init_cnt_reg  <= '0;
      length_reg    <= '0;
      scan_cnt_reg  <= '0;
      scan_last_reg <= '0;
      head_x_reg    <= '0;
      head_y_reg    <= '0;
      nx_reg        <= '0;
      ny_reg        <= '0;
      cur_dir_reg   <= 2'b00;
      eat_reg       <= 1'b0;
      done_reg      <= 1'b0;
      ate_reg       <= 1'b0;
      game_over_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      ate_reg  <= 1'b0;
      case (state_reg)
        S_INIT: begin
          init_cnt_reg <= init_cnt_reg + LEN_BITS'(1);
          if (init_last) begin
            init_cnt_reg <= '0;
            head_ptr_reg <= '0;
            length_reg   <= (LEN_BITS+1)'(INIT_LEN);
            head_x_reg   <= X_BITS'(INIT_X);
            head_y_reg   <= Y_BITS'(INIT_Y);
            cur_dir_reg  <= 2'b00;
          end
        end
        S_IDLE: begin
          if (restart) begin
            init_cnt_reg  <= '0;
            length_reg    <= '0;
            head_x_reg    <= '0;
            head_y_reg    <= '0;
            game_over_reg <= 1'b0;
          end
        end
        S_CALC: begin
          cur_dir_reg   <= new_dir;
          nx_reg        <= nx_calc;
          ny_reg        <= ny_calc;
          eat_reg       <= eat_calc;
          scan_last_reg <= k_last_calc;
          scan_cnt_reg  <= '0;
        end
        S_SCAN: scan_cnt_reg <= scan_cnt_reg + (LEN_BITS+1)'(1);
        S_COMMIT: begin
          head_ptr_reg <= head_ptr_reg - LEN_BITS'(1);
          head_x_reg   <= nx_reg;
          head_y_reg   <= ny_reg;
          // A full buffer overwrites its own tail, so length just saturates.
          if (eat_reg && length_reg != (LEN_BITS+1)'(MAX_LEN))
            length_reg <= length_reg + (LEN_BITS+1)'(1);
          done_reg <= 1'b1;
          ate_reg  <= eat_reg;
        end
        S_OVER: begin
          if (restart) begin
            init_cnt_reg  <= '0;
            length_reg    <= '0;
            head_x_reg    <= '0;
            head_y_reg    <= '0;
            game_over_reg <= 1'b0;
          end else if (!game_over_reg) begin
            // First OVER cycle: raise the flag and the single done pulse.
            game_over_reg <= 1'b1;
            done_reg      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- buffer write
  logic                wr_en;
  logic [LEN_BITS-1:0] wr_addr;
  logic [X_BITS-1:0]   wr_x;
  logic [Y_BITS-1:0]   wr_y;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = init_cnt_reg;
    wr_x    = X_BITS'(INIT_X) - X_BITS'(init_cnt_reg);
    wr_y    = Y_BITS'(INIT_Y);
    if (state_reg == S_INIT) begin
      wr_en = 1'b1;
    end else if (state_reg == S_COMMIT) begin
      wr_en   = 1'b1;
      wr_addr = head_ptr_reg - LEN_BITS'(1);
      wr_x    = nx_reg;
      wr_y    = ny_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      body_x[wr_addr] <= wr_x;
      body_y[wr_addr] <= wr_y;
    end
  end

  // ---------------------------------------------------------------- readback
  logic [LEN_BITS-1:0] rd_addr;
  logic                rd_in_range;

  assign rd_addr     = head_ptr_reg + rd_idx;
  assign rd_in_range = ({1'b0, rd_idx} < length_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_reg <= 1'b0;
      rd_x_reg     <= '0;
      rd_y_reg     <= '0;
    end else begin
      rd_valid_reg <= rd_in_range;
      rd_x_reg     <= rd_in_range ? body_x[rd_addr] : '0;
      rd_y_reg     <= rd_in_range ? body_y[rd_addr] : '0;
    end
  end

  assign rd_x      = rd_x_reg;
  assign rd_y      = rd_y_reg;
  assign rd_valid  = rd_valid_reg;
  assign done      = done_reg;
  assign ate       = ate_reg;
  assign game_over = game_over_reg;
  assign length    = length_reg;
  assign head_x    = head_x_reg;
  assign head_y    = head_y_reg;

endmodule

// File: tb/tb_snake_engine.sv
// ---------------------------------------------------------------------------
// tb_snake_engine
//   Main instance (defaults) is checked every cycle against a queue-based
//   model of the snake; the model advances at the cycle a step completes,
//   using the step latency rules. Two extra instances (MAX_LEN=4, and WRAP=1
//   with the head starting at x=15) share one stimulus and get directed
//   checks with literal expectations.
// ---------------------------------------------------------------------------
module tb_snake_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- main DUT
  logic       rst = 1'b1, step = 1'b0, restart = 1'b0;
  logic [1:0] dir = 2'b00;
  logic [3:0] food_x = 4'd0, food_y = 4'd0;
  logic [5:0] rd_idx = 6'd0;
  logic [3:0] rd_x, rd_y, head_x, head_y;
  logic       rd_valid, busy, done, ate, game_over;
  logic [6:0] length;

  snake_engine u_dut (
    .clk(clk), .rst(rst), .step(step), .dir(dir), .food_x(food_x), .food_y(food_y),
    .restart(restart), .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid),
    .busy(busy), .done(done), .ate(ate), .game_over(game_over), .length(length),
    .head_x(head_x), .head_y(head_y)
  );

  // ---------------------------------------------------------------- aux DUTs
  logic       a_rst = 1'b1, a_step = 1'b0, a_restart = 1'b0;
  logic [1:0] a_dir = 2'b00;
  logic [3:0] a_fx = 4'd0, a_fy = 4'd0;
  logic [1:0] s_rd_idx = 2'd0;
  logic [5:0] w_rd_idx = 6'd0;
  logic [3:0] s_rd_x, s_rd_y, s_hx, s_hy, w_rd_x, w_rd_y, w_hx, w_hy;
  logic       s_rv, s_busy, s_done, s_ate, s_go, w_rv, w_busy, w_done, w_ate, w_go;
  logic [2:0] s_len;
  logic [6:0] w_len;

  snake_engine #(.LEN_BITS(2)) u_small (
    .clk(clk), .rst(a_rst), .step(a_step), .dir(a_dir), .food_x(a_fx), .food_y(a_fy),
    .restart(a_restart), .rd_idx(s_rd_idx), .rd_x(s_rd_x), .rd_y(s_rd_y), .rd_valid(s_rv),
    .busy(s_busy), .done(s_done), .ate(s_ate), .game_over(s_go), .length(s_len),
    .head_x(s_hx), .head_y(s_hy)
  );

  snake_engine #(.INIT_X(15), .WRAP(1)) u_wrap (
    .clk(clk), .rst(a_rst), .step(a_step), .dir(a_dir), .food_x(a_fx), .food_y(a_fy),
    .restart(a_restart), .rd_idx(w_rd_idx), .rd_x(w_rd_x), .rd_y(w_rd_y), .rd_valid(w_rv),
    .busy(w_busy), .done(w_done), .ate(w_ate), .game_over(w_go), .length(w_len),
    .head_x(w_hx), .head_y(w_hy)
  );

  // ---------------------------------------------------------------- model
  int mbx[$];
  int mby[$];
  int m_dir, e_len, e_hx, e_hy;
  bit e_go, e_busy, e_done, e_ate;
  int er_v, er_x, er_y;
  bit cmp_en = 1'b0;

  function automatic void model_clear();
    mbx.delete(); mby.delete();
    e_len = 0; e_hx = 0; e_hy = 0; e_go = 0; e_busy = 1; e_done = 0; e_ate = 0; m_dir = 0;
  endfunction

  function automatic void model_init();
    mbx.delete(); mby.delete();
    for (int i = 0; i < 3; i++) begin
      mbx.push_back(4 - i);
      mby.push_back(4);
    end
    e_len = 3; e_hx = 4; e_hy = 4; e_go = 0; e_busy = 0; m_dir = 0;
  endfunction

  // Per-cycle comparison of the main DUT against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("ate", ate, e_ate);
      check("game_over", game_over, e_go);
      check("length", length, e_len);
      check("head_x", head_x, e_hx);
      check("head_y", head_y, e_hy);
      check("rd_valid", rd_valid, er_v);
      check("rd_x", rd_x, er_x);
      check("rd_y", rd_y, er_y);
      // Expectation for the value registered at the next edge.
      if (int'(rd_idx) < e_len) begin
        er_v = 1; er_x = mbx[rd_idx]; er_y = mby[rd_idx];
      end else begin
        er_v = 0; er_x = 0; er_y = 0;
      end
    end
  end

  // ---------------------------------------------------------------- tasks
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    er_v = 0; er_x = 0; er_y = 0;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 model_init();
  endtask

  task automatic do_restart();
    @(posedge clk); #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 model_init();
  endtask

  // Issue one step; the model decides the outcome and latency from the
  // game rules and publishes it in the cycle done is due.
  task automatic do_step(input int d, input int fx, input int fy, input bit poke, output int lat);
    int ndir, nx, ny, k, hit;
    bit wall, eat;
    ndir = (d == (m_dir ^ 1)) ? m_dir : d;
    nx = e_hx; ny = e_hy;
    case (ndir)
      0: nx++;
      1: nx--;
      2: ny++;
      default: ny--;
    endcase
    wall = (nx < 0) || (nx > 15) || (ny < 0) || (ny > 15);
    eat  = !wall && nx == fx && ny == fy;
    k    = eat ? e_len : e_len - 1;
    hit  = -1;
    if (!wall)
      for (int j = 0; j < k; j++)
        if (hit < 0 && mbx[j] == nx && mby[j] == ny) hit = j;
    lat = wall ? 2 : (hit >= 0 ? hit + 3 : k + 2);

    @(posedge clk); #1;
    step = 1'b1; dir = 2'(d); food_x = 4'(fx); food_y = 4'(fy);
    @(posedge clk); #1;
    step = 1'b0; e_busy = 1;
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      step = (poke && c == 2);
    end
    m_dir = ndir;
    if (wall || hit >= 0) begin
      e_go = 1;
    end else begin
      mbx.push_front(nx); mby.push_front(ny);
      if (!eat || e_len == 64) begin
        void'(mbx.pop_back()); void'(mby.pop_back());
      end else begin
        e_len++;
      end
      e_hx = nx; e_hy = ny;
      e_ate = eat;
    end
    e_done = 1;
    @(posedge clk); #1;
    e_done = 0; e_ate = 0; e_busy = e_go;
  endtask

  task automatic poke_step();
    @(posedge clk); #1 step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
  endtask

  task automatic read_main(input int idx, input int x, input int y, input int v);
    @(posedge clk); #1 rd_idx = 6'(idx);
    @(posedge clk); #1;
    check($sformatf("rd%0d_valid", idx), rd_valid, v);
    check($sformatf("rd%0d_x", idx), rd_x, x);
    check($sformatf("rd%0d_y", idx), rd_y, y);
  endtask

  task automatic aux_step(input int d, input int fx, input int fy,
                          output int lat_s, output int lat_w, output int ate_s, output int ate_w);
    @(posedge clk); #1;
    a_step = 1'b1; a_dir = 2'(d); a_fx = 4'(fx); a_fy = 4'(fy);
    @(posedge clk); #1 a_step = 1'b0;
    lat_s = -1; lat_w = -1; ate_s = -1; ate_w = -1;
    for (int c = 0; c < 40; c++) begin
      if (s_done && lat_s < 0) begin lat_s = c; ate_s = s_ate; end
      if (w_done && lat_w < 0) begin lat_w = c; ate_w = w_ate; end
      if (lat_s >= 0 && lat_w >= 0) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int lat, ls, lw, as, aw, t;
    repeat (2) @(posedge clk);

    // 1: reset and init
    do_reset();
    check("t1_busy", busy, 0);
    check("t1_len", length, 3);
    check("t1_hx", head_x, 4);
    check("t1_hy", head_y, 4);
    read_main(0, 4, 4, 1);
    read_main(1, 3, 4, 1);
    read_main(2, 2, 4, 1);
    read_main(3, 0, 0, 0);

    // 2: reversal ignored
    do_step(1, 9, 9, 0, lat);
    check("t2_lat", lat, 4);
    check("t2_hx", head_x, 5);
    check("t2_len", length, 3);
    read_main(2, 3, 4, 1);

    // 3: eat and grow
    do_step(0, 6, 4, 0, lat);
    check("t3_lat", lat, 5);
    check("t3_len", length, 4);
    check("t3_hx", head_x, 6);

    // 4: walk to x=15, then hit the wall
    for (int i = 0; i < 9; i++) do_step(0, 0, 0, 0, lat);
    check("t4_hx15", head_x, 15);
    do_step(0, 0, 0, 0, lat);
    check("t4_wall_lat", lat, 2);
    check("t4_go", game_over, 1);
    repeat (3) poke_step();
    repeat (4) @(posedge clk);
    #1 check("t4_go_sticky", game_over, 1);
    do_restart();
    check("t4_go_cleared", game_over, 0);
    check("t4_len", length, 3);

    // 5: square loop; head into vacating tail, then into tail with food
    do_step(0, 5, 4, 0, lat);
    do_step(2, 0, 0, 0, lat);
    do_step(1, 0, 0, 0, lat);
    do_step(3, 0, 0, 0, lat);
    check("t5_tail_lat", lat, 5);
    check("t5_tail_go", game_over, 0);
    check("t5_tail_hy", head_y, 4);
    do_step(0, 5, 4, 0, lat);
    check("t5_self_lat", lat, 6);
    check("t5_self_go", game_over, 1);
    do_restart();

    // 6: step pulsed during SCAN is dropped; reset during SCAN
    do_step(0, 9, 9, 1, lat);
    check("t6_lat", lat, 4);
    repeat (8) @(posedge clk);
    #1 check("t6_hx", head_x, 5);
    @(posedge clk); #1;
    step = 1'b1; dir = 2'b00;
    @(posedge clk); #1;
    step = 1'b0; e_busy = 1;
    do_reset();
    check("t6_rst_len", length, 3);
    check("t6_rst_hx", head_x, 4);
    repeat (3) @(posedge clk);

    // Aux: MAX_LEN=4 saturation and WRAP=1 wrap-around
    @(posedge clk); #1 a_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 a_rst = 1'b1;
    t = 0;
    while ((s_busy || w_busy) && t < 20) begin
      @(posedge clk); #1 t++;
    end
    check("aux_init_idle", int'(s_busy || w_busy), 0);
    check("s_len0", s_len, 3);
    check("w_hx0", w_hx, 15);
    aux_step(0, 5, 4, ls, lw, as, aw);
    check("s_lat1", ls, 5);
    check("s_ate1", as, 1);
    check("s_len1", s_len, 4);
    check("w_lat1", lw, 4);
    check("w_ate1", aw, 0);
    check("w_hx1", w_hx, 0);
    check("w_go1", w_go, 0);
    aux_step(0, 6, 4, ls, lw, as, aw);
    check("s_lat2", ls, 6);
    check("s_ate2", as, 1);
    check("s_len2", s_len, 4);
    check("s_hx2", s_hx, 6);
    check("w_lat2", lw, 4);
    check("w_hx2", w_hx, 1);
    s_rd_idx = 2'd3; w_rd_idx = 6'd1;
    @(posedge clk); #1;
    check("s_rd3_x", s_rd_x, 3);
    check("s_rd3_v", s_rv, 1);
    check("w_rd1_x", w_rd_x, 0);
    check("w_rd1_y", w_rd_y, 4);
    s_rd_idx = 2'd0;
    @(posedge clk); #1;
    check("s_rd0_x", s_rd_x, 6);
    check("w_len", w_len, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
